// File: rtl/flyhigh_pkg.sv
// Shared FlyHigh game types: round-phase encoding and playfield geometry
// used by bird_motion, the renderer and the collision logic.
package flyhigh_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int SCREEN_H = 480;
  localparam int BIRD_H   = 16;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a debounced button level; the press
// output is high for the single cycle where the level is high but was low.
module btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  logic btn_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) btn_q <= 1'b0;
    else       btn_q <= i_btn;
  end

  assign o_press = i_btn & ~btn_q;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical motion: flap requests, per-frame gravity, ceiling clamp,
// ground death and IDLE/FLY/DEAD round phases. Define FLYHIGH_FLAP_REPEAT_EN
// to make a held button re-flap every REPEAT_FRAMES ticks.
module bird_motion #(
  parameter int Y_W           = 10,
  parameter int V_W           = 6,
  parameter int SCREEN_H      = flyhigh_pkg::SCREEN_H,
  parameter int BIRD_H        = flyhigh_pkg::BIRD_H,
  parameter int Y_START       = 232,
  parameter int GRAVITY       = 1,
  parameter int FLAP_IMPULSE  = 8,
  parameter int V_MAX         = 10,
  parameter int REPEAT_FRAMES = 12
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_btn_state,
  input  logic           i_frame_tick,
  input  logic           i_collide,
  input  logic           i_restart,
  output logic [Y_W-1:0] o_bird_y,
  output logic [V_W-1:0] o_vel,
  output logic [1:0]     o_state,
  output logic           o_flap,
  output logic           o_dead
);

  import flyhigh_pkg::*;

  localparam logic signed [V_W:0]   V_MAX_W  = (V_W+1)'(V_MAX);
  localparam logic signed [V_W-1:0] V_LIM    = V_W'(V_MAX);
  localparam logic signed [V_W-1:0] V_FLAP   = V_W'(-FLAP_IMPULSE);
  localparam logic signed [Y_W+1:0] Y_ZERO   = '0;
  localparam logic signed [Y_W+1:0] Y_GROUND = (Y_W+2)'(SCREEN_H - BIRD_H);
  localparam logic [Y_W-1:0]        Y_FLOOR  = Y_W'(SCREEN_H - BIRD_H);
  localparam logic [Y_W-1:0]        Y_INIT   = Y_W'(Y_START);

  state_t                state;
  logic                  press;
  logic                  flap_pending;
  logic                  rep_hit;
  logic                  flap_req;
  logic signed [V_W-1:0] vel;
  logic [Y_W-1:0]        bird_y;
  logic signed [V_W:0]   v_grav;
  logic signed [V_W-1:0] v_next;
  logic signed [Y_W+1:0] y_sum;
  logic                  hit_ceiling;
  logic                  hit_ground;

  btn_edge u_btn_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_state),
    .o_press (press)
  );

`ifdef FLYHIGH_FLAP_REPEAT_EN
  localparam int C_W = $clog2(REPEAT_FRAMES + 1);
  logic [C_W-1:0] hold_cnt;

  // The repeat flap lands on the tick that completes the held period.
  assign rep_hit = (state == FLY) & i_frame_tick & i_btn_state
                 & (hold_cnt == C_W'(REPEAT_FRAMES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                           hold_cnt <= '0;
    else if (state != FLY || i_restart || !i_btn_state) hold_cnt <= '0;
    else if (i_frame_tick)                               hold_cnt <= rep_hit ? '0 : hold_cnt + 1'b1;
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_comb begin
    flap_req = flap_pending | press | rep_hit;
    v_grav   = {vel[V_W-1], vel} + (V_W+1)'(GRAVITY);
    if (flap_req)            v_next = V_FLAP;
    else if (v_grav > V_MAX_W) v_next = V_LIM;
    else                     v_next = v_grav[V_W-1:0];
    y_sum       = {2'b00, bird_y} + {{(Y_W+2-V_W){v_next[V_W-1]}}, v_next};
    hit_ceiling = (y_sum <= Y_ZERO);
    hit_ground  = (y_sum >= Y_GROUND);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      bird_y       <= Y_INIT;
      vel          <= '0;
      flap_pending <= 1'b0;
      o_flap       <= 1'b0;
      o_dead       <= 1'b0;
    end else begin
      o_flap <= 1'b0;
      if (i_restart && state != IDLE) begin
        state        <= IDLE;
        bird_y       <= Y_INIT;
        vel          <= '0;
        flap_pending <= 1'b0;
        o_dead       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (press) begin
              state        <= FLY;
              flap_pending <= 1'b1;
            end
          end
          FLY: begin
            // Collision wins over a same-cycle tick: nothing moves on that tick.
            if (i_collide) begin
              state        <= DEAD;
              o_dead       <= 1'b1;
              flap_pending <= 1'b0;
            end else if (i_frame_tick) begin
              flap_pending <= 1'b0;
              o_flap       <= flap_req;
              if (hit_ceiling) begin
                bird_y <= '0;
                vel    <= '0;
              end else if (hit_ground) begin
                bird_y <= Y_FLOOR;
                vel    <= v_next;
                state  <= DEAD;
                o_dead <= 1'b1;
              end else begin
                bird_y <= y_sum[Y_W-1:0];
                vel    <= v_next;
              end
            end else if (press) begin
              flap_pending <= 1'b1;
            end
          end
          DEAD: flap_pending <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_bird_y = bird_y;
  assign o_vel    = vel;
  assign o_state  = state;

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboard bench for bird_motion: directed round scenarios plus random
// play, checked against an integer reference model of the motion rules.
module tb_bird_motion;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_btn_state;
  logic       i_frame_tick;
  logic       i_collide;
  logic       i_restart;
  logic [9:0] o_bird_y;
  logic [5:0] o_vel;
  logic [1:0] o_state;
  logic       o_flap;
  logic       o_dead;

  bird_motion dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_btn_state  (i_btn_state),
    .i_frame_tick (i_frame_tick),
    .i_collide    (i_collide),
    .i_restart    (i_restart),
    .o_bird_y     (o_bird_y),
    .o_vel        (o_vel),
    .o_state      (o_state),
    .o_flap       (o_flap),
    .o_dead       (o_dead)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int y;
    int v;
    int st;
    bit flap;
    bit dead;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  int m_y, m_v, m_st, m_cnt;
  bit m_fp, m_btnq, m_flap;

  function automatic void model_reset();
    m_y = 232; m_v = 0; m_st = 0; m_cnt = 0;
    m_fp = 0; m_btnq = 0; m_flap = 0;
  endfunction

  function automatic void model_step(bit btn, bit tick, bit col, bit rs);
    bit press, rep, f;
    int nv, ny;
    press  = btn && !m_btnq;
    m_btnq = btn;
    m_flap = 0;
    rep    = 0;
    if (rs && m_st != 0) begin
      m_st = 0; m_y = 232; m_v = 0; m_fp = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      m_cnt = 0;
      if (press) begin m_st = 1; m_fp = 1; end
    end else if (m_st == 1) begin
      if (col) begin
        m_st = 2; m_fp = 0; m_cnt = 0;
      end else begin
`ifdef FLYHIGH_FLAP_REPEAT_EN
        if (!btn) m_cnt = 0;
        else if (tick) begin
          if (m_cnt == 11) begin rep = 1; m_cnt = 0; end
          else m_cnt++;
        end
`endif
        if (tick) begin
          f  = m_fp || press || rep;
          nv = f ? -8 : ((m_v + 1 > 10) ? 10 : m_v + 1);
          ny = m_y + nv;
          if (ny <= 0)        begin m_y = 0;   m_v = 0; end
          else if (ny >= 464) begin m_y = 464; m_v = nv; m_st = 2; end
          else                begin m_y = ny;  m_v = nv; end
          m_fp   = 0;
          m_flap = f;
        end else if (press) begin
          m_fp = 1;
        end
      end
    end else begin
      m_fp = 0;
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit btn, bit tick, bit col, bit rs);
    @(negedge i_clk);
    i_btn_state  = btn;
    i_frame_tick = tick;
    i_collide    = col;
    i_restart    = rs;
    model_step(btn, tick, col, rs);
    sb.push_back('{m_y, m_v, m_st, m_flap, (m_st == 2)});
  endtask

  task automatic settle();
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_y",    int'(o_bird_y),       e.y);
        chk("sb_vel",  int'($signed(o_vel)), e.v);
        chk("sb_state", int'(o_state),      e.st);
        chk("sb_flap", int'(o_flap),         int'(e.flap));
        chk("sb_dead", int'(o_dead),         int'(e.dead));
      end
    end
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int flaps;
    int exp_flaps;
    bit btn_r;
    i_rst = 1'b1; i_btn_state = 0; i_frame_tick = 0; i_collide = 0; i_restart = 0;
    model_reset();
    #1;
    chk("reset_y",     int'(o_bird_y), 232);
    chk("reset_vel",   int'($signed(o_vel)), 0);
    chk("reset_state", int'(o_state), 0);
    chk("reset_flap",  int'(o_flap), 0);
    chk("reset_dead",  int'(o_dead), 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    cyc(0, 0, 0, 0);

    // start a round; pending flap lands on the first tick
    cyc(1, 0, 0, 0); settle;
    chk("press_to_fly", int'(o_state), 1);
    cyc(1, 1, 0, 0); settle;
    chk("first_tick_y",    int'(o_bird_y), 224);
    chk("first_tick_v",    int'($signed(o_vel)), -8);
    chk("first_tick_flap", int'(o_flap), 1);
    cyc(0, 0, 0, 0); settle;
    chk("flap_one_cycle",  int'(o_flap), 0);

    // flap repeatedly into the ceiling
    repeat (40) begin cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); end
    settle;
    chk("ceiling_y",     int'(o_bird_y), 0);
    chk("ceiling_v",     int'($signed(o_vel)), 0);
    chk("ceiling_state", int'(o_state), 1);

    // free fall with saturation: 1+..+10+10+10 = 75
    repeat (12) begin cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); end
    settle;
    chk("gravity_y", int'(o_bird_y), 75);
    chk("gravity_v", int'($signed(o_vel)), 10);

    k = 0;
    while (o_state != 2'd2 && k < 100) begin
      cyc(0, 1, 0, 0); settle; k++;
    end
    chk("ground_state", int'(o_state), 2);
    chk("ground_y",     int'(o_bird_y), 464);
    chk("ground_dead",  int'(o_dead), 1);

    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); settle;
    chk("dead_frozen_y",     int'(o_bird_y), 464);
    chk("dead_frozen_state", int'(o_state), 2);
    cyc(0, 0, 0, 1); settle;
    chk("restart_state", int'(o_state), 0);
    chk("restart_y",     int'(o_bird_y), 232);
    chk("restart_dead",  int'(o_dead), 0);

    // collision beats a same-cycle tick and press
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 1, 1, 0); settle;
    chk("collide_state", int'(o_state), 2);
    chk("collide_y",     int'(o_bird_y), 224);
    chk("collide_flap",  int'(o_flap), 0);

    // held button across 25 ticks
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    flaps = 0;
    repeat (25) begin
      cyc(1, 1, 0, 0); settle;
      if (o_flap) flaps++;
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    end
`ifdef FLYHIGH_FLAP_REPEAT_EN
    exp_flaps = 3;
`else
    exp_flaps = 1;
`endif
    chk("hold_flaps", flaps, exp_flaps);

    // asynchronous reset mid-round
    cyc(0, 0, 0, 0); cyc(0, 1, 0, 0);
    @(negedge i_clk);
    #2;
    i_rst = 1'b1; i_btn_state = 0; i_frame_tick = 0; i_collide = 0; i_restart = 0;
    #1;
    chk("async_rst_y",     int'(o_bird_y), 232);
    chk("async_rst_vel",   int'($signed(o_vel)), 0);
    chk("async_rst_state", int'(o_state), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();

    btn_r = 0;
    repeat (3000) begin
      if ($urandom_range(0, 5) == 0) btn_r = ~btn_r;
      cyc(btn_r, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 59) == 0);
    end

    repeat (3) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
